// File: rtl/uart_rx_pkg.sv
// Shared types and width helpers for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic first-word-fall-through FIFO; push-to-visible latency 1 cycle.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is left unreset; the empty gate below keeps the output clean.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a FWFT FIFO; char visible 1 cycle after the stop sample.
// Full FIFO drops chars and sets sticky overflow. Optional parity via UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rxd,
  output logic [DATA_BITS-1:0]                m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [level_width(FIFO_DEPTH)-1:0]  level,
  output logic                                frame_err,
  output logic                                overflow,
  input  logic                                clr_overflow
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                                parity_odd,
  output logic                                parity_err
`endif
);

  localparam int             CW         = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BIT    = 4'(DATA_BITS - 1);

  logic                 rxd_m;
  logic                 rxd_s;
  logic                 rxd_p;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  assign tick = (cnt == '0);
  assign push = (state == ST_STOP) && tick && rxd_s;
  assign pop  = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rxd_p && !rxd_s) begin
            cnt   <= HALF_RELOAD;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (rxd_s) begin
            state <= ST_IDLE;
          end else begin
            cnt     <= BIT_RELOAD;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            cnt   <= BIT_RELOAD;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Data XOR parity bit must equal the selected sense (0 even, 1 odd).
            par_bad <= (^shreg) ^ rxd_s ^ parity_odd;
            cnt     <= BIT_RELOAD;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (rxd_s) begin
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign m_valid = !empty;

endmodule
